// File: rtl/ldtu_stream_decoder.sv
// LiTE-DTU 32-bit stream receiver: unpacks baseline/signal words into one
// 12-bit sample per clock and checks frame trailers for count/number consistency.
module ldtu_stream_decoder #(
  parameter int Nbits_12 = 12,
  parameter int Nbits_32 = 32,
  parameter int Nbits_8  = 8
) (
  input  logic                CLK_A,
  input  logic                reset_A,
  input  logic [Nbits_32-1:0] word_in,
  input  logic                word_valid,
  output logic                word_ready,
  output logic [Nbits_12-1:0] sample_out,
  output logic                sample_gain01,
  output logic                sample_baseline,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                frame_ok,
  output logic                frame_error,
  output logic                header_error
);

  // One stored sample is {gain01, amplitude}.
  localparam int SW = Nbits_12 + 1;
  localparam logic [Nbits_32-1:0] IDLE_WORD = 32'hEAAAAAAA;

  typedef enum logic {EMPTY, UNPACK} state_t;
  typedef enum logic [2:0] {
    W_IDLE, W_BASE, W_SIG2, W_SIG1, W_TRAIL, W_BAD
  } kind_t;

  state_t               state;
  logic [3:0][SW-1:0]   shift_q;
  logic [2:0]           remaining;
  logic [Nbits_8-1:0]   frame_cnt;
  logic [Nbits_8-1:0]   last_fn;
  logic                 fn_check_en;

  kind_t                kind;
  logic [4:0][SW-1:0]   dec_samples;
  logic [2:0]           dec_count;
  logic                 dec_base;
  logic [Nbits_8-1:0]   expected_fn;
  logic                 count_match;
  logic                 fn_match;
  logic                 word_accept;
  logic                 sample_fire;

  assign word_ready  = (state == EMPTY) || (remaining == 3'd1 && sample_ready);
  assign word_accept = word_valid && word_ready;
  assign sample_fire = sample_valid && sample_ready;

  // Header classification; the idle pattern is matched before any header field.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    kind = W_BAD;
    if (word_in == IDLE_WORD)             kind = W_IDLE;
    else if (word_in[31:30] == 2'b01)     kind = W_BASE;
    else if (word_in[31:26] == 6'b001010) kind = W_SIG2;
    else if (word_in[31:26] == 6'b001011) kind = W_SIG1;
    else if (word_in[31:28] == 4'b1101)   kind = W_TRAIL;
  end

  always_comb begin
    dec_samples = '0;
    dec_count   = 3'd0;
    dec_base    = 1'b0;
    case (kind)
      W_BASE: begin
        for (int i = 0; i < 5; i++) dec_samples[i] = SW'(word_in[6*i +: 6]);
        dec_count = 3'd5;
        dec_base  = 1'b1;
      end
      W_SIG2: begin
        dec_samples[0] = word_in[12:0];
        dec_samples[1] = word_in[25:13];
        dec_count      = 3'd2;
      end
      W_SIG1: begin
        dec_samples[0] = word_in[12:0];
        dec_count      = 3'd1;
      end
      default: ;
    endcase
  end

  assign expected_fn = last_fn + Nbits_8'(1);
  assign count_match = (word_in[27:20] == frame_cnt);
  assign fn_match    = !fn_check_en || (word_in[19:12] == expected_fn);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values; later assignments in the block take priority.
  always_ff @(posedge CLK_A) begin
    if (reset_A) begin
      state           <= EMPTY;
      shift_q         <= '0;
      remaining       <= 3'd0;
      frame_cnt       <= '0;
      last_fn         <= '0;
      fn_check_en     <= 1'b0;
      sample_out      <= '0;
      sample_gain01   <= 1'b0;
      sample_baseline <= 1'b0;
      sample_valid    <= 1'b0;
      frame_ok        <= 1'b0;
      frame_error     <= 1'b0;
      header_error    <= 1'b0;
    end else begin
      frame_ok     <= 1'b0;
      frame_error  <= 1'b0;
      header_error <= 1'b0;

      if (sample_fire) begin
        if (remaining > 3'd1) begin
          {sample_gain01, sample_out} <= shift_q[0];
          shift_q   <= {{SW{1'b0}}, shift_q[3:1]};
          remaining <= remaining - 3'd1;
        end else begin
          state        <= EMPTY;
          sample_valid <= 1'b0;
          remaining    <= 3'd0;
        end
      end

      // A new word is only accepted when the payload is empty or draining its
      // last sample, so loading here overrides the EMPTY transition above.
      if (word_accept) begin
        case (kind)
          W_BASE, W_SIG2, W_SIG1: begin
            state                       <= UNPACK;
            sample_valid                <= 1'b1;
            {sample_gain01, sample_out} <= dec_samples[0];
            sample_baseline             <= dec_base;
            shift_q                     <= dec_samples[4:1];
            remaining                   <= dec_count;
            frame_cnt                   <= frame_cnt + Nbits_8'(dec_count);
          end
          W_TRAIL: begin
            frame_ok    <= count_match && fn_match;
            frame_error <= !(count_match && fn_match);
            frame_cnt   <= '0;
            last_fn     <= word_in[19:12];
            fn_check_en <= 1'b1;
          end
          W_BAD:   header_error <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ldtu_stream_decoder.sv
// Self-checking bench for ldtu_stream_decoder: directed scenarios plus a
// randomized stream scored against a sample-queue model of the word formats.
module tb_ldtu_stream_decoder;

  logic        CLK_A = 1'b0;
  logic        reset_A;
  logic [31:0] word_in;
  logic        word_valid;
  logic        word_ready;
  logic [11:0] sample_out;
  logic        sample_gain01;
  logic        sample_baseline;
  logic        sample_valid;
  logic        sample_ready;
  logic        frame_ok;
  logic        frame_error;
  logic        header_error;

  ldtu_stream_decoder dut (
    .CLK_A           (CLK_A),
    .reset_A         (reset_A),
    .word_in         (word_in),
    .word_valid      (word_valid),
    .word_ready      (word_ready),
    .sample_out      (sample_out),
    .sample_gain01   (sample_gain01),
    .sample_baseline (sample_baseline),
    .sample_valid    (sample_valid),
    .sample_ready    (sample_ready),
    .frame_ok        (frame_ok),
    .frame_error     (frame_error),
    .header_error    (header_error)
  );

  always #5 CLK_A = ~CLK_A;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  int rdy_mode = 0;  // 0: always ready, 1: toggle, 2: random

  typedef struct {
    logic [11:0] amp;
    logic        gain;
    logic        base;
  } samp_t;

  // Reference model: queue of samples still owed, frame bookkeeping, pulses due.
  samp_t      mq[$];
  samp_t      f;
  int         m_cnt = 0;
  int         m_last_fn = 0;
  bit         m_fn_en = 1'b0;
  logic [2:0] exp_pulse = 3'b000;  // {frame_ok, frame_error, header_error}
  logic       exp_ready;

  task automatic model_word(input logic [31:0] w);
    samp_t s;
    bit ok;
    if (w == 32'hEAAAAAAA) begin
      // idle: nothing
    end else if (w[31:30] == 2'b01) begin
      for (int i = 0; i < 5; i++) begin
        s.amp = 12'((w >> (6 * i)) & 32'h3F); s.gain = 1'b0; s.base = 1'b1;
        mq.push_back(s);
      end
      m_cnt = (m_cnt + 5) % 256;
    end else if (w[31:26] == 6'b001010 || w[31:26] == 6'b001011) begin
      s.amp = 12'(w & 32'hFFF); s.gain = w[12]; s.base = 1'b0;
      mq.push_back(s);
      if (w[26] == 1'b0) begin
        s.amp = 12'((w >> 13) & 32'hFFF); s.gain = w[25];
        mq.push_back(s);
        m_cnt = (m_cnt + 2) % 256;
      end else begin
        m_cnt = (m_cnt + 1) % 256;
      end
    end else if (w[31:28] == 4'b1101) begin
      ok = (int'(w[27:20]) == m_cnt) &&
           (!m_fn_en || int'(w[19:12]) == (m_last_fn + 1) % 256);
      exp_pulse = ok ? 3'b100 : 3'b010;
      m_cnt = 0;
      m_last_fn = int'(w[19:12]);
      m_fn_en = 1'b1;
    end else begin
      exp_pulse = 3'b001;
    end
  endtask

  // Monitor: inputs change 1 time unit after posedge, so the negedge sees the
  // exact values the next posedge will act on.
  always @(negedge CLK_A) begin
    if (mon_en) begin
      checks++;
      if (sample_valid !== (mq.size() != 0)) begin
        errors++;
        $display("FAIL mon_valid t=%0t got=%b exp=%b", $time, sample_valid, mq.size() != 0);
      end
      exp_ready = (mq.size() == 0) || (mq.size() == 1 && sample_ready);
      checks++;
      if (word_ready !== exp_ready) begin
        errors++;
        $display("FAIL mon_ready t=%0t got=%b exp=%b", $time, word_ready, exp_ready);
      end
      if (sample_valid === 1'b1 && mq.size() != 0) begin
        f = mq[0];
        checks++;
        if ({sample_out, sample_gain01, sample_baseline} !== {f.amp, f.gain, f.base}) begin
          errors++;
          $display("FAIL mon_sample t=%0t got amp=%h g=%b b=%b exp amp=%h g=%b b=%b",
                   $time, sample_out, sample_gain01, sample_baseline, f.amp, f.gain, f.base);
        end
      end
      checks++;
      if ({frame_ok, frame_error, header_error} !== exp_pulse) begin
        errors++;
        $display("FAIL mon_pulses t=%0t got ok/err/hdr=%b%b%b exp=%b",
                 $time, frame_ok, frame_error, header_error, exp_pulse);
      end
      exp_pulse = 3'b000;
      if (reset_A) begin
        mq.delete();
        m_cnt = 0;
        m_last_fn = 0;
        m_fn_en = 1'b0;
      end else begin
        if (sample_valid && sample_ready && mq.size() != 0) void'(mq.pop_front());
        if (word_valid && word_ready) model_word(word_in);
      end
    end
  end

  initial begin
    sample_ready = 1'b1;
    forever begin
      @(posedge CLK_A); #1;
      case (rdy_mode)
        0:       sample_ready = 1'b1;
        1:       sample_ready = ~sample_ready;
        default: sample_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset_A = 1'b1;
    word_valid = 1'b0;
    repeat (2) @(posedge CLK_A);
    #1 reset_A = 1'b0;
  endtask

  // Offers a word until it is accepted; returns 1 time unit after the accepting edge.
  task automatic send_word(input logic [31:0] w);
    int n;
    word_in = w;
    word_valid = 1'b1;
    for (n = 0; n < 200; n++) begin
      @(negedge CLK_A);
      if (word_ready === 1'b1) break;
    end
    checks++;
    if (n == 200) begin
      errors++;
      $display("FAIL send_timeout word=%h never accepted", w);
    end
    @(posedge CLK_A); #1;
    word_valid = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge CLK_A); #1;
  endtask

  task automatic test_reset();
    word_in = '0;
    word_valid = 1'b0;
    rdy_mode = 0;
    do_reset();
    @(negedge CLK_A);
    checks++;
    if ({sample_valid, sample_out, sample_gain01, sample_baseline} !== 15'd0) begin
      errors++;
      $display("FAIL reset_sample got valid=%b out=%h g=%b b=%b exp all 0",
               sample_valid, sample_out, sample_gain01, sample_baseline);
    end
    checks++;
    if ({frame_ok, frame_error, header_error} !== 3'b000) begin
      errors++;
      $display("FAIL reset_pulses got=%b%b%b exp=000", frame_ok, frame_error, header_error);
    end
    checks++;
    if (word_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got=%b exp=1", word_ready);
    end
    mon_en = 1'b1;
    next_cycle();
  endtask

  task automatic test_baseline_ones();
    rdy_mode = 0;
    send_word(32'h7FFFFFFF);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK_A);
      checks++;
      if ({sample_valid, sample_out, sample_baseline, sample_gain01} !== {1'b1, 12'h03F, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL base_sample%0d got valid=%b out=%h b=%b g=%b exp 1 03f 1 0",
                 i, sample_valid, sample_out, sample_baseline, sample_gain01);
      end
      if (i == 4) begin
        checks++;
        if (word_ready !== 1'b1) begin
          errors++;
          $display("FAIL base_last_ready got=%b exp=1", word_ready);
        end
      end
    end
    @(negedge CLK_A);
    checks++;
    if (sample_valid !== 1'b0) begin
      errors++;
      $display("FAIL base_done_valid got=%b exp=0", sample_valid);
    end
    next_cycle();
  endtask

  task automatic test_signal2_backpressure();
    logic [11:0] exp_amp[2];
    logic        exp_gain[2];
    int k;
    exp_amp[0] = 12'h123; exp_gain[0] = 1'b0;
    exp_amp[1] = 12'hABC; exp_gain[1] = 1'b1;
    rdy_mode = 1;
    send_word({6'b001010, 13'h1ABC, 13'h0123});
    k = 0;
    for (int c = 0; c < 20 && k < 2; c++) begin
      @(negedge CLK_A);
      checks++;
      if ({sample_valid, sample_out, sample_gain01, sample_baseline} !== {1'b1, exp_amp[k], exp_gain[k], 1'b0}) begin
        errors++;
        $display("FAIL sig2_sample%0d got valid=%b out=%h g=%b b=%b exp 1 %h %b 0",
                 k, sample_valid, sample_out, sample_gain01, sample_baseline, exp_amp[k], exp_gain[k]);
      end
      checks++;
      if (word_ready !== (k == 1 && sample_ready)) begin
        errors++;
        $display("FAIL sig2_ready k=%0d got=%b exp=%b", k, word_ready, k == 1 && sample_ready);
      end
      if (sample_ready) k++;
    end
    checks++;
    if (k != 2) begin
      errors++;
      $display("FAIL sig2_timeout transfers=%0d exp=2", k);
    end
    rdy_mode = 0;
    next_cycle();
  endtask

  task automatic check_pulses(input string name, input logic [2:0] exp);
    @(negedge CLK_A);
    checks++;
    if ({frame_ok, frame_error, header_error} !== exp) begin
      errors++;
      $display("FAIL %s got ok/err/hdr=%b%b%b exp=%b", name, frame_ok, frame_error, header_error, exp);
    end
    next_cycle();
  endtask

  task automatic test_frame_check();
    rdy_mode = 0;
    do_reset();
    send_word({2'b01, 30'($urandom)});
    send_word({2'b01, 30'($urandom)});
    send_word({6'b001011, 26'($urandom)});
    send_word({4'b1101, 8'd11, 8'd7, 12'h0});
    check_pulses("frame_ok_first", 3'b100);
    send_word({6'b001011, 26'($urandom)});
    send_word({4'b1101, 8'd1, 8'd9, 12'h0});
    check_pulses("frame_err_fn", 3'b010);
  endtask

  task automatic test_idle_bad();
    rdy_mode = 0;
    send_word(32'hEAAAAAAA);
    check_pulses("idle_no_pulse", 3'b000);
    send_word(32'hF0000000);
    check_pulses("bad_header", 3'b001);
    send_word({4'b1101, 8'd0, 8'd10, 12'hABC});
    check_pulses("idle_bad_count_kept", 3'b100);
  endtask

  task automatic test_mid_reset();
    rdy_mode = 0;
    send_word({2'b01, 30'($urandom)});
    @(posedge CLK_A);
    @(posedge CLK_A); #1;
    reset_A = 1'b1;
    @(posedge CLK_A); #1;
    reset_A = 1'b0;
    @(negedge CLK_A);
    checks++;
    if (sample_valid !== 1'b0 || word_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset got valid=%b ready=%b exp valid=0 ready=1", sample_valid, word_ready);
    end
    next_cycle();
    send_word({4'b1101, 8'd0, 8'd3, 12'h0});
    check_pulses("mid_reset_trailer", 3'b100);
  endtask

  task automatic test_wrap();
    rdy_mode = 0;
    for (int i = 0; i < 52; i++) send_word({2'b01, 30'($urandom)});
    send_word({4'b1101, 8'd4, 8'd4, 12'h0});
    check_pulses("wrap_count", 3'b100);
  endtask

  task automatic test_back_to_back();
    rdy_mode = 0;
    fork
      begin
        for (int i = 0; i < 3; i++) send_word({6'b001010, 26'($urandom)});
      end
      begin
        int n;
        bit seen;
        seen = 1'b0;
        for (n = 0; n < 20 && !seen; n++) begin
          @(negedge CLK_A);
          if (sample_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
          errors++;
          $display("FAIL b2b_start got valid=0 exp=1");
        end
        for (int k = 1; k < 6; k++) begin
          @(negedge CLK_A);
          checks++;
          if (sample_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_bubble sample%0d got valid=%b exp=1", k, sample_valid);
          end
        end
        @(negedge CLK_A);
        checks++;
        if (sample_valid !== 1'b0) begin
          errors++;
          $display("FAIL b2b_end got valid=%b exp=0", sample_valid);
        end
      end
    join
    next_cycle();
  endtask

  task automatic test_random();
    logic [31:0] w;
    logic [7:0]  cnt_f, fn_f;
    rdy_mode = 2;
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 9))
        0:       w = 32'hEAAAAAAA;
        1, 2, 3: w = {2'b01, 30'($urandom)};
        4, 5:    w = {6'b001010, 26'($urandom)};
        6:       w = {6'b001011, 26'($urandom)};
        7:       w = {4'b1111, 28'($urandom)};
        default: begin
          cnt_f = ($urandom_range(0, 1) == 1) ? 8'(m_cnt) : 8'($urandom);
          fn_f  = ($urandom_range(0, 1) == 1) ? 8'(m_last_fn + 1) : 8'($urandom);
          w = {4'b1101, cnt_f, fn_f, 12'($urandom)};
        end
      endcase
      send_word(w);
    end
    rdy_mode = 0;
  endtask

  initial begin
    test_reset();
    test_baseline_ones();
    test_signal2_backpressure();
    test_frame_check();
    test_idle_bad();
    test_mid_reset();
    test_wrap();
    test_back_to_back();
    test_random();
    for (int c = 0; c < 100 && (mq.size() != 0 || sample_valid !== 1'b0); c++) @(negedge CLK_A);
    repeat (2) @(negedge CLK_A);
    checks++;
    if (mq.size() != 0 || sample_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain pending_model=%0d valid=%b exp 0 0", mq.size(), sample_valid);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ldtu_stream_decoder.md
Name: ldtu_stream_decoder

Overview:
- Back-end-side receiver for the LiTE-DTU 32-bit output stream: accepts encoded 32-bit words and unpacks them into one 12-bit sample per clock.
- Each sample carries a gain tag and a baseline tag.
- Checks frame trailers for sample-count and frame-number consistency; silently drops idle words.
- Used in the test-bench/emulator chain and in the off-detector firmware model, directly after the serializer/deserializer.

Parameters:
- Nbits_12, 12, decoded sample amplitude width
- Nbits_32, 32, input word width
- Nbits_8, 8, width of the trailer count and frame-number fields and of the internal counters

Ports:
- CLK_A  input  1  single system clock; all state updates on its rising edge
- reset_A  input  1  synchronous, active-high reset
- word_in  input  32  encoded word from the DTU stream
- word_valid  input  1  word_in is valid this cycle
- word_ready  output  1  decoder accepts word_in this cycle; transfer when word_valid & word_ready
- sample_out  output  12  decoded sample amplitude
- sample_gain01  output  1  1 = gain-1 sample, 0 = gain-10 sample
- sample_baseline  output  1  sample came from a baseline word
- sample_valid  output  1  sample_* valid
- sample_ready  input  1  downstream accepts the sample; transfer when sample_valid & sample_ready
- frame_ok  output  1  one-cycle pulse: trailer matched
- frame_error  output  1  one-cycle pulse: trailer sample-count or frame-number mismatch
- header_error  output  1  one-cycle pulse: unknown header, word dropped

Behaviour:
- Word formats, checked in this order:
  - Idle: word == 32'hEAAAAAAA. Dropped, no pulse.
  - Baseline: [31:30]=2'b01. Five 6-bit samples; sample0=[5:0] up to sample4=[29:24]. Each is zero-extended to 12 bits, gain01=0, baseline=1.
  - Signal-2: [31:26]=6'b001010. Two 13-bit samples; sample0=[12:0], sample1=[25:13]. Bit 12 of each is gain01, [11:0] is amplitude, baseline=0.
  - Signal-1: [31:26]=6'b001011. One sample in [12:0], same field split as Signal-2.
  - Trailer: [31:28]=4'b1101. [27:20]=sample count of the frame mod 256, [19:12]=frame number, [11:0] ignored.
  - Anything else: header_error.
- States:
  - EMPTY: no samples pending.
  - UNPACK: holds the accepted payload in a shift register and a 3-bit remaining counter (1..5).
- word_ready = (state==EMPTY) | (remaining==1 & sample_ready). It is combinational from state and sample_ready only, never from word_valid.
- Latency: a data word accepted at edge N presents its first sample on sample_out after edge N (visible in cycle N+1). Each further sample follows one cycle after the previous sample transfers. With sample_ready held high, back-to-back words stream with no bubble.
- On a sample transfer, the shift register advances by one sample and remaining decrements. When remaining reaches 0 with no new word accepted, the state goes to EMPTY.
- sample_* outputs are registered and hold stable while sample_valid=1 and sample_ready=0.
- Idle, trailer and bad-header words are consumed in one cycle and produce no sample. If one of them is accepted while the last sample transfers, the state goes to EMPTY.
- Frame sample counter (8 bits): on acceptance of a data word it adds that word's sample count (5, 2 or 1), mod 256.
- Trailer accepted:
  - Compare [27:20] with the counter, and [19:12] with the expected frame number (last trailer frame number + 1 mod 256).
  - The frame-number check is disabled until the first trailer after reset.
  - Pulse frame_ok or frame_error on the next cycle.
  - Clear the counter to 0, load last-frame-number = [19:12], and set the frame-number check to enabled.
- All pulses are registered, exactly one cycle wide, and fire in the cycle after acceptance.
- Reset (synchronous, any time including mid-UNPACK):
  - Pending samples are discarded; state=EMPTY.
  - Counter=0, last-frame-number=0, frame-number check disabled.
  - sample_valid=0, sample_out=0, sample_gain01=0, sample_baseline=0, frame_ok=0, frame_error=0, header_error=0.
  - word_ready=1 in the first cycle after reset.
- word_valid with word_ready=0: the word is neither consumed nor counted; the upstream must hold it.

Test Plan:
- Reset, then word 32'h7FFFFFFF, sample_ready=1 → five samples 12'h03F, baseline=1, gain01=0, on 5 consecutive cycles starting 1 cycle after acceptance; word_ready=1 in the cycle the 5th sample transfers.
- Signal-2 word {6'b001010, 13'h1ABC, 13'h0123} with sample_ready toggling 1/0 → outputs 12'h123 gain01=0, then 12'hABC gain01=1; values hold while sample_ready=0; word_ready stays low until the last transfer.
- Two baseline words + one Signal-1 (11 samples), then trailer {4'b1101, 8'd11, 8'd7, 12'h0} → frame_ok pulse. Then a Signal-1, then trailer {4'b1101, 8'd1, 8'd9, 12'h0} → frame_error pulse (expected frame number 8).
- Words 32'hEAAAAAAA and 32'hF0000000 → no samples; header_error pulses only for the second; counter unchanged.
- Mid-UNPACK reset after 2 of 5 baseline samples → next cycle sample_valid=0, word_ready=1; a following trailer with count 0 gives frame_ok.
- Stream of 52 baseline words (260 samples), then trailer with count 8'd4 → frame_ok (counter wraps mod 256).
